// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry holding buffers (A = ALU, B = load return) drained
// round-robin into a registered register-file write port, with a pending-register mask.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic [7:0]           conflict_cnt
);

  logic              r_a_vld;
  logic [ADDR_W-1:0] r_a_addr;
  logic [DATA_W-1:0] r_a_data;
  logic              r_b_vld;
  logic [ADDR_W-1:0] r_b_addr;
  logic [DATA_W-1:0] r_b_data;
  logic              r_rr_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_conflict;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_hs_a;
  logic              w_hs_b;
  logic [2**ADDR_W-1:0] w_pend;

  // rr_last=1 means B went last, so A takes the next conflict
  assign w_grant_a = r_a_vld && (!r_b_vld || r_rr_last);
  assign w_grant_b = r_b_vld && (!r_a_vld || !r_rr_last);

  assign a_ready = !r_a_vld || w_grant_a;
  assign b_ready = !r_b_vld || w_grant_b;
  assign w_hs_a  = a_valid && a_ready;
  assign w_hs_b  = b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_vld    <= 1'b0;
      r_a_addr   <= '0;
      r_a_data   <= '0;
      r_b_vld    <= 1'b0;
      r_b_addr   <= '0;
      r_b_data   <= '0;
      r_rr_last  <= 1'b1;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_conflict <= '0;
    end else begin
      if (w_grant_a) begin
        r_we      <= 1'b1;
        r_waddr   <= r_a_addr;
        r_wdata   <= r_a_data;
        r_rr_last <= 1'b0;
      end else if (w_grant_b) begin
        r_we      <= 1'b1;
        r_waddr   <= r_b_addr;
        r_wdata   <= r_b_data;
        r_rr_last <= 1'b1;
      end else begin
        r_we      <= 1'b0;
      end

      // A same-cycle refill takes priority over the drain of a granted buffer
      if (w_hs_a) begin
        r_a_vld  <= 1'b1;
        r_a_addr <= a_addr;
        r_a_data <= a_data;
      end else if (w_grant_a) begin
        r_a_vld  <= 1'b0;
      end

      if (w_hs_b) begin
        r_b_vld  <= 1'b1;
        r_b_addr <= b_addr;
        r_b_data <= b_data;
      end else if (w_grant_b) begin
        r_b_vld  <= 1'b0;
      end

      if (r_a_vld && r_b_vld && (r_conflict != 8'hFF))
        r_conflict <= r_conflict + 8'd1;
    end
  end

  always_comb begin
    w_pend = '0;
    if (r_a_vld) w_pend[r_a_addr] = 1'b1;
    if (r_b_vld) w_pend[r_b_addr] = 1'b1;
    if (r_we)    w_pend[r_waddr]  = 1'b1;
  end

  assign pend_mask    = w_pend;
  assign write_enable = r_we;
  assign write_addr   = r_waddr;
  assign write_data   = r_wdata;
  assign conflict_cnt = r_conflict;

endmodule
